// File: rtl/err_metric_acc.sv
// Error-metric accumulator for approximate-multiplier characterisation: counts pairs,
// mismatches, sum/max of |exact-apprx|. Define ERR_METRIC_SIGNED_ED_EN to add signed sum_ed.
module err_metric_acc #(
    parameter int unsigned N_SAMPLES = 10000,
    parameter int unsigned PW        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PW-1:0]        exact,
    input  logic [PW-1:0]        apprx,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          sample_cnt,
    output logic [31:0]          n_err,
    output logic [PW+23:0]       sum_abs_ed,
    output logic [PW-1:0]        max_ed
`ifdef ERR_METRIC_SIGNED_ED_EN
    ,
    output logic signed [PW+24:0] sum_ed
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      sample_cnt_q, sample_cnt_d;
    logic [31:0]      n_err_q, n_err_d;
    logic [PW+23:0]   sum_abs_ed_q, sum_abs_ed_d;
    logic [PW-1:0]    max_ed_q, max_ed_d;
`ifdef ERR_METRIC_SIGNED_ED_EN
    logic signed [PW+24:0] sum_ed_q, sum_ed_d;
`endif

    logic signed [PW:0] diff;
    logic [PW-1:0]      abs_ed;
    logic               last_pair;

    // Difference taken one bit wider so its magnitude always fits back into PW bits.
    always_comb begin
        diff      = $signed({1'b0, exact}) - $signed({1'b0, apprx});
        abs_ed    = diff[PW] ? PW'(-diff) : diff[PW-1:0];
        last_pair = (sample_cnt_q == 32'(N_SAMPLES - 1));
    end

    always_comb begin
        state_d      = state_q;
        sample_cnt_d = sample_cnt_q;
        n_err_d      = n_err_q;
        sum_abs_ed_d = sum_abs_ed_q;
        max_ed_d     = max_ed_q;
`ifdef ERR_METRIC_SIGNED_ED_EN
        sum_ed_d     = sum_ed_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = RUN;
                    sample_cnt_d = '0;
                    n_err_d      = '0;
                    sum_abs_ed_d = '0;
                    max_ed_d     = '0;
`ifdef ERR_METRIC_SIGNED_ED_EN
                    sum_ed_d     = '0;
`endif
                end
            end
            RUN: begin
                if (in_valid) begin
                    sample_cnt_d = sample_cnt_q + 32'd1;
                    if (abs_ed != '0) begin
                        n_err_d = n_err_q + 32'd1;
                    end
                    sum_abs_ed_d = sum_abs_ed_q + (PW+24)'(abs_ed);
                    if (abs_ed > max_ed_q) begin
                        max_ed_d = abs_ed;
                    end
`ifdef ERR_METRIC_SIGNED_ED_EN
                    sum_ed_d = sum_ed_q + (PW+25)'(diff);
`endif
                    if (last_pair) begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sample_cnt_q <= '0;
            n_err_q      <= '0;
            sum_abs_ed_q <= '0;
            max_ed_q     <= '0;
`ifdef ERR_METRIC_SIGNED_ED_EN
            sum_ed_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            sample_cnt_q <= sample_cnt_d;
            n_err_q      <= n_err_d;
            sum_abs_ed_q <= sum_abs_ed_d;
            max_ed_q     <= max_ed_d;
`ifdef ERR_METRIC_SIGNED_ED_EN
            sum_ed_q     <= sum_ed_d;
`endif
        end
    end

    always_comb begin
        in_ready   = (state_q == RUN);
        busy       = (state_q == RUN);
        done       = (state_q == DONE);
        sample_cnt = sample_cnt_q;
        n_err      = n_err_q;
        sum_abs_ed = sum_abs_ed_q;
        max_ed     = max_ed_q;
`ifdef ERR_METRIC_SIGNED_ED_EN
        sum_ed     = sum_ed_q;
`endif
    end

endmodule

// File: tb/tb_err_metric_acc.sv
// Self-checking bench for err_metric_acc: vector table, corner-case sequences and
// randomized runs against a behavioural model of the run/accumulate rules.
module tb_err_metric_acc;

    localparam int unsigned N  = 4;
    localparam int unsigned PW = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   exact;
    logic [PW-1:0]   apprx;
    logic            busy;
    logic            done;
    logic [31:0]     sample_cnt;
    logic [31:0]     n_err;
    logic [PW+23:0]  sum_abs_ed;
    logic [PW-1:0]   max_ed;
`ifdef ERR_METRIC_SIGNED_ED_EN
    logic signed [PW+24:0] sum_ed;
`endif

    err_metric_acc #(.N_SAMPLES(N), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .exact      (exact),
        .apprx      (apprx),
        .busy       (busy),
        .done       (done),
        .sample_cnt (sample_cnt),
        .n_err      (n_err),
        .sum_abs_ed (sum_abs_ed),
        .max_ed     (max_ed)
`ifdef ERR_METRIC_SIGNED_ED_EN
        ,
        .sum_ed     (sum_ed)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a run is "open" after start until N pairs were taken.
    bit     m_running, m_finished;
    longint m_cnt, m_nerr, m_sum, m_max, m_sumed;

    function automatic void model_reset();
        m_running = 0; m_finished = 0;
        m_cnt = 0; m_nerr = 0; m_sum = 0; m_max = 0; m_sumed = 0;
    endfunction

    function automatic void model_step(input bit s, input bit v,
                                       input longint ex, input longint ap);
        longint d, a;
        if (!m_running) begin
            if (s) begin
                m_running = 1; m_finished = 0;
                m_cnt = 0; m_nerr = 0; m_sum = 0; m_max = 0; m_sumed = 0;
            end
        end else if (v) begin
            d = ex - ap;
            a = (d < 0) ? -d : d;
            m_cnt++;
            if (a != 0) m_nerr++;
            m_sum += a;
            m_sumed += d;
            if (a > m_max) m_max = a;
            if (m_cnt == N) begin
                m_running = 0; m_finished = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},   64'(in_ready),   64'(m_running));
        chk({tag, ".busy"},       64'(busy),       64'(m_running));
        chk({tag, ".done"},       64'(done),       64'(m_finished));
        chk({tag, ".sample_cnt"}, 64'(sample_cnt), m_cnt);
        chk({tag, ".n_err"},      64'(n_err),      m_nerr);
        chk({tag, ".sum_abs_ed"}, 64'(sum_abs_ed), m_sum);
        chk({tag, ".max_ed"},     64'(max_ed),     m_max);
`ifdef ERR_METRIC_SIGNED_ED_EN
        chk({tag, ".sum_ed"},     $signed(sum_ed), m_sumed);
`endif
    endtask

    // One clock: drive, let the edge happen, sample 1 time unit later.
    task automatic cycle(input string tag, input bit s, input bit v,
                         input logic [PW-1:0] ex, input logic [PW-1:0] ap);
        start = s; in_valid = v; exact = ex; apprx = ap;
        @(posedge clk); #1;
        model_step(s, v, longint'(ex), longint'(ap));
        start = 1'b0; in_valid = 1'b0;
        check_all(tag);
    endtask

    typedef struct {
        logic [PW-1:0]  ex;
        logic [PW-1:0]  ap;
        logic [31:0]    cnt;
        logic [31:0]    nerr;
        logic [PW+23:0] sum;
        logic [PW-1:0]  mx;
        logic           dn;
        logic           rdy;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{ex:16'd100,   ap:16'd100, cnt:1, nerr:0, sum:0,     mx:0,     dn:0, rdy:1};
        tbl[1] = '{ex:16'd200,   ap:16'd196, cnt:2, nerr:1, sum:4,     mx:4,     dn:0, rdy:1};
        tbl[2] = '{ex:16'd50,    ap:16'd58,  cnt:3, nerr:2, sum:12,    mx:8,     dn:0, rdy:1};
        tbl[3] = '{ex:16'd65535, ap:16'd0,   cnt:4, nerr:3, sum:65547, mx:65535, dn:1, rdy:0};

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; exact = '0; apprx = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;
        cycle("idle_valid", 0, 1, 16'd9, 16'd1);

        cycle("start", 1, 0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            start = 1'b0; in_valid = 1'b1; exact = tbl[i].ex; apprx = tbl[i].ap;
            @(posedge clk); #1;
            model_step(0, 1, longint'(tbl[i].ex), longint'(tbl[i].ap));
            in_valid = 1'b0;
            chk($sformatf("tbl%0d.cnt", i),  64'(sample_cnt), 64'(tbl[i].cnt));
            chk($sformatf("tbl%0d.nerr", i), 64'(n_err),      64'(tbl[i].nerr));
            chk($sformatf("tbl%0d.sum", i),  64'(sum_abs_ed), 64'(tbl[i].sum));
            chk($sformatf("tbl%0d.max", i),  64'(max_ed),     64'(tbl[i].mx));
            chk($sformatf("tbl%0d.done", i), 64'(done),       64'(tbl[i].dn));
            chk($sformatf("tbl%0d.rdy", i),  64'(in_ready),   64'(tbl[i].rdy));
`ifdef ERR_METRIC_SIGNED_ED_EN
            if (i == 2) chk("tbl2.sum_ed", $signed(sum_ed), -64'sd4);
`endif
        end
        cycle("done_5th", 0, 1, 16'd9, 16'd1);
        chk("done_5th.cnt", 64'(sample_cnt), 64'd4);
        cycle("done_hold", 0, 0, '0, '0);

        cycle("restart", 1, 0, '0, '0);
        chk("restart.busy", 64'(busy), 64'd1);
        chk("restart.done", 64'(done), 64'd0);
        chk("restart.sum",  64'(sum_abs_ed), 64'd0);
        chk("restart.max",  64'(max_ed), 64'd0);

        cycle("r37a", 0, 1, 16'd7, 16'd7);
        cycle("r37_start", 1, 0, '0, '0);
        chk("r37_start.cnt", 64'(sample_cnt), 64'd1);
        cycle("r37b", 0, 1, 16'd3, 16'd1);
        chk("r37b.cnt", 64'(sample_cnt), 64'd2);

        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.cnt", 64'(sample_cnt), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle("post_rst", 0, 1, 16'd5, 16'd3);

        cycle("r36_start", 1, 0, '0, '0);
        cycle("r36a", 0, 1, 16'd65535, 16'd0);
        cycle("r36b", 0, 1, 16'd0, 16'd65535);
        chk("r36.max", 64'(max_ed),     64'd65535);
        chk("r36.sum", 64'(sum_abs_ed), 64'd131070);
`ifdef ERR_METRIC_SIGNED_ED_EN
        chk("r36.sum_ed", $signed(sum_ed), 64'sd0);
`endif

        for (int run = 0; run < 8; run++) begin
            cycle($sformatf("rnd%0d_start", run), 1, 0, '0, '0);
            for (int c = 0; c < 14; c++) begin
                logic [PW-1:0] ex, ap;
                bit v, s;
                ex = PW'($urandom);
                case ($urandom_range(0, 3))
                    0: ap = ex;
                    1: ap = ($urandom_range(0, 1) != 0) ? '1 : '0;
                    default: ap = PW'($urandom);
                endcase
                v = ($urandom_range(0, 3) != 0);
                s = ($urandom_range(0, 9) == 0);
                cycle($sformatf("rnd%0d_%0d", run, c), s, v, ex, ap);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
